// File: rtl/ccr_branch_unit.sv
// Architectural status register (result + C,V,N,Z flags) fed by the arithmetic stage, plus a
// two-state query engine that evaluates branch conditions against it with a registered response.
module ccr_branch_unit #(
  parameter int op_size  = 4,
  parameter int cnt_size = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [op_size-1:0]  in_r,
  input  logic [3:0]          in_ccr,
  output logic [op_size-1:0]  r_out,
  output logic [3:0]          ccr_out,
  output logic [cnt_size-1:0] upd_cnt,
  input  logic                q_valid,
  output logic                q_ready,
  input  logic [3:0]          q_cond,
  output logic                t_valid,
  input  logic                t_ready,
  output logic                t_taken,
  output logic [3:0]          t_ccr
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  typedef enum logic [3:0] {
    COND_AL = 4'h0, COND_NV = 4'h1, COND_HI = 4'h2, COND_LS = 4'h3,
    COND_CC = 4'h4, COND_CS = 4'h5, COND_NE = 4'h6, COND_EQ = 4'h7,
    COND_VC = 4'h8, COND_VS = 4'h9, COND_PL = 4'hA, COND_MI = 4'hB,
    COND_GE = 4'hC, COND_LT = 4'hD, COND_GT = 4'hE, COND_LE = 4'hF
  } cond_e;

  state_e                r_state;
  logic [op_size-1:0]    r_r;
  logic [3:0]            r_ccr;
  logic [cnt_size-1:0]   r_cnt;
  logic                  r_t_valid;
  logic                  r_t_taken;
  logic [3:0]            r_t_ccr;

  logic                  w_upd_fire;
  logic                  w_q_fire;
  logic [3:0]            w_eval_ccr;
  logic                  w_taken;

  // CCR bit order is [3]=C [2]=V [1]=N [0]=Z.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] ccr);
    logic c, v, n, z;
    c = ccr[3];
    v = ccr[2];
    n = ccr[1];
    z = ccr[0];
    case (cond_e'(cond))
      COND_AL: return 1'b1;
      COND_NV: return 1'b0;
      COND_HI: return ~c & ~z;
      COND_LS: return c | z;
      COND_CC: return ~c;
      COND_CS: return c;
      COND_NE: return ~z;
      COND_EQ: return z;
      COND_VC: return ~v;
      COND_VS: return v;
      COND_PL: return ~n;
      COND_MI: return n;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return ~z & (n == v);
      default: return z | (n != v);
    endcase
  endfunction

  // in_ready never looks at q_valid, so a held response also freezes the CCR it was computed on.
  assign in_ready   = (r_state == IDLE) | t_ready;
  assign q_ready    = (r_state == IDLE);
  assign w_upd_fire = in_valid & in_ready;
  assign w_q_fire   = q_valid & q_ready;

  // A same-cycle update is forwarded so the query sees the flags that are being written.
  assign w_eval_ccr = w_upd_fire ? in_ccr : r_ccr;
  assign w_taken    = cond_eval(q_cond, w_eval_ccr);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_r   <= '0;
      r_ccr <= '0;
      r_cnt <= '0;
    end else if (w_upd_fire) begin
      r_r   <= in_r;
      r_ccr <= in_ccr;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_t_valid <= 1'b0;
      r_t_taken <= 1'b0;
      r_t_ccr   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_q_fire) begin
            r_state   <= RESP;
            r_t_valid <= 1'b1;
            r_t_taken <= w_taken;
            r_t_ccr   <= w_eval_ccr;
          end
        end
        default: begin
          if (t_ready) begin
            r_state   <= IDLE;
            r_t_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  assign r_out   = r_r;
  assign ccr_out = r_ccr;
  assign upd_cnt = r_cnt;
  assign t_valid = r_t_valid;
  assign t_taken = r_t_taken;
  assign t_ccr   = r_t_ccr;

endmodule
